// File: rtl/bpb_assoc.sv
// Set-associative branch prediction buffer: SETS x WAYS entries of {valid, tag, target, counter}
// with zero-latency lookup, one resolve-stage update per cycle and per-set LRU replacement.
module bpb_assoc #(
    parameter int SETS  = 16,
    parameter int WAYS  = 2,
    parameter int CNT_W = 2,
    parameter int TAG_W = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int AGE_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic               valid_q  [SETS][WAYS];
    logic [TAG_W-1:0]   tag_q    [SETS][WAYS];
    logic [31:0]        target_q [SETS][WAYS];
    logic [CNT_W-1:0]   cnt_q    [SETS][WAYS];
    logic [AGE_W-1:0]   age_q    [SETS][WAYS];

    logic [INDEX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;

    assign lk_idx = lookup_pc[INDEX_W+1:2];
    assign lk_tag = lookup_pc[INDEX_W+TAG_W+1:INDEX_W+2];
    assign up_idx = upd_pc[INDEX_W+1:2];
    assign up_tag = upd_pc[INDEX_W+TAG_W+1:INDEX_W+2];

    // Lookup reads only registered state, so same-cycle updates show up next cycle.
    always_comb begin
        hit            = 1'b0;
        predict_taken  = 1'b0;
        predict_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                hit            = 1'b1;
                predict_taken  = cnt_q[lk_idx][w][CNT_W-1];
                predict_target = target_q[lk_idx][w];
            end
        end
    end

    logic             upd_hit;
    logic [AGE_W-1:0] hit_way, victim_way, touch_way, touch_age;
    logic [CNT_W-1:0] hit_cnt, cnt_nxt;

    always_comb begin
        upd_hit    = 1'b0;
        hit_way    = '0;
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
                upd_hit = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (age_q[up_idx][w] == AGE_W'(WAYS - 1))
                victim_way = AGE_W'(w);
        end
        // Any invalid way beats the LRU way; descending scan leaves the lowest index.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[up_idx][w])
                victim_way = AGE_W'(w);
        end
        touch_way = upd_hit ? hit_way : victim_way;
        touch_age = age_q[up_idx][touch_way];
        hit_cnt   = cnt_q[up_idx][hit_way];
        cnt_nxt   = hit_cnt;
        if (upd_taken && hit_cnt != {CNT_W{1'b1}})
            cnt_nxt = hit_cnt + CNT_W'(1);
        else if (!upd_taken && hit_cnt != '0)
            cnt_nxt = hit_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w]  <= 1'b0;
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
                    cnt_q[s][w]    <= '0;
                    age_q[s][w]    <= AGE_W'(w);
                end
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++)
                    valid_q[s][w] <= 1'b0;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                cnt_q[up_idx][hit_way] <= cnt_nxt;
                if (upd_taken)
                    target_q[up_idx][hit_way] <= upd_target;
            end else if (upd_taken) begin
                valid_q[up_idx][victim_way]  <= 1'b1;
                tag_q[up_idx][victim_way]    <= up_tag;
                target_q[up_idx][victim_way] <= upd_target;
                cnt_q[up_idx][victim_way]    <= CNT_W'(1) << (CNT_W - 1);
            end
            // Touch keeps the set's ages a permutation of 0..WAYS-1.
            if (upd_hit || upd_taken) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGE_W'(w) == touch_way)
                        age_q[up_idx][w] <= '0;
                    else if (age_q[up_idx][w] < touch_age)
                        age_q[up_idx][w] <= age_q[up_idx][w] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bpb_assoc.sv
// Directed bench for bpb_assoc (SETS=16, WAYS=2, CNT_W=2, TAG_W=26) with hand-computed expectations.
module tb_bpb_assoc;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [31:0] lookup_pc;
    logic        hit, predict_taken;
    logic [31:0] predict_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    int n_pass  = 0;
    int n_total = 0;

    bpb_assoc #(.SETS(16), .WAYS(2), .CNT_W(2), .TAG_W(26)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .lookup_pc      (lookup_pc),
        .hit            (hit),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_en = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
        tick();
        upd_en = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic e_hit,
                        input logic e_taken, input logic [31:0] e_tgt);
        lookup_pc = pc;
        #1;
        check({tag, ".hit"},    {31'd0, hit},           {31'd0, e_hit});
        check({tag, ".taken"},  {31'd0, predict_taken}, {31'd0, e_taken});
        check({tag, ".target"}, predict_target,         e_tgt);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; lookup_pc = '0;
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        tick(); tick();
        reset = 1'b0;

        look("reset", 32'h1000, 0, 0, 32'h0);

        // Allocation lands at weakly taken (10), then saturate at 11.
        upd(32'h1000, 1, 32'h2000);
        look("alloc", 32'h1000, 1, 1, 32'h2000);
        upd(32'h1000, 1, 32'h2000);
        upd(32'h1000, 1, 32'h2000);
        look("sat_hi", 32'h1000, 1, 1, 32'h2000);
        upd(32'h1000, 0, 32'hdead0000);
        look("nt1", 32'h1000, 1, 1, 32'h2000);
        upd(32'h1000, 0, 32'hdead0000);
        look("nt2", 32'h1000, 1, 0, 32'h2000);
        upd(32'h1000, 0, 32'h0);
        upd(32'h1000, 0, 32'h0);
        look("sat_lo", 32'h1000, 1, 0, 32'h2000);

        // Not-taken miss allocates nothing; taken hit from 00 goes to 01 with new target.
        upd(32'h3000, 0, 32'h7000);
        look("nt_miss", 32'h3000, 0, 0, 32'h0);
        upd(32'h1000, 1, 32'h2400);
        look("tgt_upd", 32'h1000, 1, 0, 32'h2400);

        // LRU in set 0 from a clean table.
        reset = 1'b1; tick(); reset = 1'b0;
        upd(32'h1000, 1, 32'h2000);
        upd(32'h1040, 1, 32'h3040);
        look("two_ways", 32'h1040, 1, 1, 32'h3040);
        upd(32'h1000, 1, 32'h2100);
        upd(32'h1080, 1, 32'h3080);
        look("evicted", 32'h1040, 0, 0, 32'h0);
        look("kept", 32'h1000, 1, 1, 32'h2100);
        look("new", 32'h1080, 1, 1, 32'h3080);
        look("other_set", 32'h1004, 0, 0, 32'h0);

        // Flush wins over a same-cycle update.
        flush = 1'b1;
        upd(32'h5000, 1, 32'h6000);
        flush = 1'b0;
        look("fl_1000", 32'h1000, 0, 0, 32'h0);
        look("fl_1080", 32'h1080, 0, 0, 32'h0);
        look("fl_5000", 32'h5000, 0, 0, 32'h0);
        upd(32'h1000, 1, 32'h2000);
        look("realloc", 32'h1000, 1, 1, 32'h2000);
        upd(32'h1000, 0, 32'h0);
        look("realloc_cnt", 32'h1000, 1, 0, 32'h2000);

        // Lookup shows pre-update state; the update is visible next cycle.
        lookup_pc = 32'h1000;
        upd_en = 1'b1; upd_pc = 32'h1000; upd_taken = 1'b1; upd_target = 32'h2000;
        #1;
        check("same_cycle.taken", {31'd0, predict_taken}, 32'd0);
        tick();
        upd_en = 1'b0;
        look("next_cycle", 32'h1000, 1, 1, 32'h2000);

        // Reset wins over a same-cycle update.
        reset = 1'b1;
        upd(32'h1000, 1, 32'h2200);
        reset = 1'b0;
        look("mid_reset", 32'h1000, 0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
